// File: rtl/f1_ctrl.sv
// f1_ctrl: conv1 feature-RAM sequencer -- byte-stream image load, then 5x5 window tap scan.
// Optional macro F1_CTRL_PERF_EN adds perf_cycles, a CONV/DRAIN cycle counter.
module f1_ctrl #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 5,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        load_done,
  input  logic        conv_start,
  input  logic        conv_hold,
  output logic [3:0]  f1_wr_en,
  output logic [31:0] f1_waddr,
  output logic [31:0] f1_wdata,
  output logic        f1_ena,
  output logic [9:0]  f1_raddr,
  input  logic [7:0]  f1_rdata,
  output logic [7:0]  tap_data,
  output logic        tap_valid,
  output logic        win_first,
  output logic        win_last,
  output logic        conv_done,
  output logic        busy
`ifdef F1_CTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_LOADED = 2'd1;
  localparam logic [1:0] S_CONV   = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam logic [9:0] LAST_PIX = 10'(IMG_W * IMG_H - 1);
  localparam logic [9:0] W10      = 10'(IMG_W);
  localparam logic [9:0] KM1      = 10'(K - 1);
  localparam logic [9:0] OX_MAX   = 10'(IMG_W - K);
  localparam logic [9:0] OY_MAX   = 10'(IMG_H - K);

  logic [1:0]        state_reg;
  logic [9:0]        n_reg;
  logic [9:0]        oy_reg, ox_reg, ky_reg, kx_reg;
  logic [RD_LAT-1:0] vld_bits, first_bits, last_bits;
  logic              accept, issue, is_first, is_last;
  logic              kx_wrap, ky_wrap, ox_wrap, oy_wrap, scan_end;

  assign pix_ready = (state_reg == S_LOAD) && !rst;
  assign accept    = pix_valid && pix_ready;
  assign issue     = (state_reg == S_CONV) && !conv_hold;
  assign kx_wrap   = (kx_reg == KM1);
  assign ky_wrap   = (ky_reg == KM1);
  assign ox_wrap   = (ox_reg == OX_MAX);
  assign oy_wrap   = (oy_reg == OY_MAX);
  assign scan_end  = kx_wrap && ky_wrap && ox_wrap && oy_wrap;
  assign is_first  = (kx_reg == 10'd0) && (ky_reg == 10'd0);
  assign is_last   = kx_wrap && ky_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_LOAD;
      n_reg     <= 10'd0;
    end else begin
      case (state_reg)
        S_LOAD: begin
          if (accept) begin
            if (n_reg == LAST_PIX) begin
              n_reg     <= 10'd0;
              state_reg <= S_LOADED;
            end else begin
              n_reg <= n_reg + 10'd1;
            end
          end
        end
        S_LOADED: if (conv_start) state_reg <= S_CONV;
        S_CONV:   if (issue && scan_end) state_reg <= S_DRAIN;
        S_DRAIN:  if (vld_bits == '0) state_reg <= S_LOAD;
        default:  state_reg <= S_LOAD;
      endcase
    end
  end

  // Counters wrap back to zero after the final tap, ready for the next image.
  always_ff @(posedge clk) begin
    if (rst) begin
      kx_reg <= 10'd0;
      ky_reg <= 10'd0;
      ox_reg <= 10'd0;
      oy_reg <= 10'd0;
    end else if (issue) begin
      kx_reg <= kx_wrap ? 10'd0 : kx_reg + 10'd1;
      if (kx_wrap) ky_reg <= ky_wrap ? 10'd0 : ky_reg + 10'd1;
      if (kx_wrap && ky_wrap) ox_reg <= ox_wrap ? 10'd0 : ox_reg + 10'd1;
      if (kx_wrap && ky_wrap && ox_wrap) oy_reg <= oy_wrap ? 10'd0 : oy_reg + 10'd1;
    end
  end

  assign f1_raddr = (oy_reg + ky_reg) * W10 + (ox_reg + kx_reg);

  always_ff @(posedge clk) begin
    if (rst || !accept) begin
      f1_wr_en <= 4'h0;
      f1_ena   <= 1'b0;
      f1_waddr <= 32'd0;
      f1_wdata <= 32'd0;
    end else begin
      f1_wr_en <= 4'hF;
      f1_ena   <= 1'b1;
      f1_waddr <= {20'd0, n_reg, 2'b00};
      f1_wdata <= {24'd0, pix_in};
    end
  end

  // Tag pipeline matching the RAM read latency.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
      logic v_reg, f_reg, l_reg;
      logic v_in, f_in, l_in;
      if (gi == 0) begin : g_head
        assign v_in = issue;
        assign f_in = issue && is_first;
        assign l_in = issue && is_last;
      end else begin : g_link
        assign v_in = vld_bits[gi-1];
        assign f_in = first_bits[gi-1];
        assign l_in = last_bits[gi-1];
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          v_reg <= 1'b0;
          f_reg <= 1'b0;
          l_reg <= 1'b0;
        end else begin
          v_reg <= v_in;
          f_reg <= f_in;
          l_reg <= l_in;
        end
      end
      assign vld_bits[gi]   = v_reg;
      assign first_bits[gi] = f_reg;
      assign last_bits[gi]  = l_reg;
    end
  endgenerate

  assign tap_valid = vld_bits[RD_LAT-1];
  assign win_first = first_bits[RD_LAT-1];
  assign win_last  = last_bits[RD_LAT-1];
  assign tap_data  = tap_valid ? f1_rdata : 8'd0;
  assign load_done = (state_reg == S_LOADED) && !rst;
  assign conv_done = (state_reg == S_DRAIN) && (vld_bits == '0) && !rst;
  assign busy      = pix_ready || (((state_reg == S_CONV) || (state_reg == S_DRAIN)) && !rst);

`ifdef F1_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= 32'd0;
    end else if ((state_reg == S_LOADED) && conv_start) begin
      perf_cycles <= 32'd0;
    end else if ((state_reg == S_CONV) || (state_reg == S_DRAIN)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_f1_ctrl.sv
// tb_f1_ctrl: directed load/scan/hold/reset sequence with a behavioural 2-cycle RAM
// and a window-arithmetic reference model for the tap stream.
module tb_f1_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pix_in = 8'd0;
  logic        pix_valid = 1'b0;
  logic        conv_start = 1'b0;
  logic        conv_hold = 1'b0;
  logic        pix_ready, load_done, f1_ena, tap_valid, win_first, win_last, conv_done, busy;
  logic [3:0]  f1_wr_en;
  logic [31:0] f1_waddr, f1_wdata;
  logic [9:0]  f1_raddr;
  logic [7:0]  f1_rdata, tap_data;
`ifdef F1_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  f1_ctrl dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .load_done(load_done), .conv_start(conv_start), .conv_hold(conv_hold),
    .f1_wr_en(f1_wr_en), .f1_waddr(f1_waddr), .f1_wdata(f1_wdata), .f1_ena(f1_ena),
    .f1_raddr(f1_raddr), .f1_rdata(f1_rdata), .tap_data(tap_data), .tap_valid(tap_valid),
    .win_first(win_first), .win_last(win_last), .conv_done(conv_done), .busy(busy)
`ifdef F1_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: byte write port, 2-cycle registered read.
  logic [7:0] ram [0:1023];
  logic [7:0] rd_q1 = 8'd0, rd_q2 = 8'd0;
  initial for (int i = 0; i < 1024; i++) ram[i] = 8'd0;
  always @(posedge clk) begin
    if (f1_ena && f1_wr_en == 4'hF) ram[f1_waddr[11:2]] <= f1_wdata[7:0];
    rd_q1 <= ram[f1_raddr];
    rd_q2 <= rd_q1;
  end
  assign f1_rdata = rd_q2;

  // Monitor: write-port legality and tap capture.
  int         wr_cnt = 0, wr_bad = 0, wr_idx = 0, flag_bad = 0, done_cnt = 0, done_cyc = 0;
  logic       acc_pend = 1'b0;
  logic [7:0] pend_pix = 8'd0;
  logic [9:0] h1 = 10'd0, h2 = 10'd0;
  int         tap_addr_q[$], tap_cyc_q[$];
  logic [7:0] tap_data_q[$];
  bit         tap_first_q[$], tap_last_q[$];

  always @(negedge clk) begin
    if (f1_wr_en != 4'h0 || f1_ena) begin
      wr_cnt++;
      if (!acc_pend || f1_wr_en !== 4'hF || !f1_ena ||
          f1_waddr !== {20'd0, wr_idx[9:0], 2'b00} || f1_wdata !== {24'd0, pend_pix})
        wr_bad++;
      wr_idx++;
    end else if (acc_pend) begin
      wr_bad++;
    end
    acc_pend = pix_valid && pix_ready;
    pend_pix = pix_in;
    if (tap_valid) begin
      tap_addr_q.push_back(int'(h2));
      tap_data_q.push_back(tap_data);
      tap_first_q.push_back(win_first);
      tap_last_q.push_back(win_last);
      tap_cyc_q.push_back(cyc);
    end else if (win_first || win_last) begin
      flag_bad++;
    end
    h2 = h1;
    h1 = f1_raddr;
    if (conv_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int checks = 0, errors = 0, rdy_bad = 0;
  logic [7:0] pat [0:1023];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: tap t belongs to window t/25 (row-major over 28x28), kernel position t%25.
  function automatic int win_addr(input int t);
    int w, k;
    w = t / 25;
    k = t % 25;
    return ((w / 28) + (k / 5)) * 32 + (w % 28) + (k % 5);
  endfunction

  task automatic load_img(input int count, input bit gapped, input int pulse_at);
    for (int n = 0; n < count; n++) begin
      if (gapped) begin
        pix_valid  = 1'b0;
        conv_start = 1'b0;
        tick();
      end
      if (n == 1023) check("load_done_before_last", {31'd0, load_done}, 32'd0);
      if (pix_ready !== 1'b1) rdy_bad++;
      pix_valid  = 1'b1;
      pix_in     = pat[n];
      conv_start = (n == pulse_at);
      tick();
    end
    pix_valid  = 1'b0;
    conv_start = 1'b0;
  endtask

  task automatic clear_taps();
    tap_addr_q.delete(); tap_data_q.delete(); tap_first_q.delete();
    tap_last_q.delete(); tap_cyc_q.delete();
    done_cnt = 0;
    flag_bad = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    check("conv_done_seen", done_cnt, 32'd1);
    tick();
  endtask

  function automatic int ram_bad();
    int b = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== pat[i]) b++;
    return b;
  endfunction

  int         c0, h, w, bad, nf, nl, in_win, late;
  int         first_exp [7] = '{0, 1, 2, 3, 4, 32, 33};
  int         ref_addr_q[$];
  logic [7:0] ref_data_q[$];
  bit         ref_first_q[$], ref_last_q[$];

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_wr_en", {28'd0, f1_wr_en}, 32'd0);
    check("rst_tap_valid", {31'd0, tap_valid}, 32'd0);
    check("rst_raddr", {22'd0, f1_raddr}, 32'd0);
    rst = 1'b0;
    tick();
    check("load_pix_ready", {31'd0, pix_ready}, 32'd1);
    check("load_busy", {31'd0, busy}, 32'd1);
    $display("reset: done at cycle %0d", cyc);

    // Back-to-back ramp load
    for (int i = 0; i < 1024; i++) pat[i] = 8'(i);
    wr_cnt = 0; wr_idx = 0; wr_bad = 0; rdy_bad = 0;
    load_img(1024, 1'b0, -1);
    check("ramp_load_done", {31'd0, load_done}, 32'd1);
    check("ramp_pix_ready_low", {31'd0, pix_ready}, 32'd0);
    check("ramp_busy_low", {31'd0, busy}, 32'd0);
    check("ramp_last_waddr", f1_waddr, 32'h0000_0FFC);
    check("ramp_last_wdata", f1_wdata, 32'h0000_00FF);
    tick();
    check("ramp_wr_cnt", wr_cnt, 32'd1024);
    check("ramp_wr_bad", wr_bad, 32'd0);
    check("ramp_rdy_bad", rdy_bad, 32'd0);
    check("ramp_wr_idle", {28'd0, f1_wr_en}, 32'd0);
    check("ramp_ram", ram_bad(), 32'd0);
    $display("load ramp: writes=%0d", wr_cnt);

    // Scan without hold
    clear_taps();
    conv_start = 1'b1;
    c0 = cyc;
    tick();
    conv_start = 1'b0;
    check("conv_busy", {31'd0, busy}, 32'd1);
    wait_done(25000);
    check("nohold_done_latency", done_cyc - c0, 32'd19603);
    check("nohold_first_tap_lat", (tap_cyc_q.size() > 0) ? tap_cyc_q[0] - c0 : -1, 32'd3);
    check("nohold_taps", tap_addr_q.size(), 32'd19600);
    for (int i = 0; i < 7; i++)
      check("nohold_first_addr", (tap_addr_q.size() > i) ? tap_addr_q[i] : -1, first_exp[i]);
    check("last_win_addr", (tap_addr_q.size() > 783 * 25) ? tap_addr_q[783 * 25] : -1, 32'd891);
    bad = 0; nf = 0; nl = 0;
    for (int t = 0; t < tap_addr_q.size() && t < 19600; t++) begin
      if (tap_addr_q[t] != win_addr(t) || tap_data_q[t] !== pat[win_addr(t)] ||
          tap_first_q[t] != (t % 25 == 0) || tap_last_q[t] != (t % 25 == 24)) bad++;
      nf += int'(tap_first_q[t]);
      nl += int'(tap_last_q[t]);
    end
    check("nohold_tap_seq", bad, 32'd0);
    check("nohold_win_first", nf, 32'd784);
    check("nohold_win_last", nl, 32'd784);
    check("nohold_flag_bad", flag_bad, 32'd0);
    check("after_conv_pix_ready", {31'd0, pix_ready}, 32'd1);
    check("after_conv_load_done", {31'd0, load_done}, 32'd0);
    check("conv_done_pulse", done_cnt, 32'd1);
`ifdef F1_CTRL_PERF_EN
    check("perf_nohold", perf_cycles, 32'd19603);
`endif
    ref_addr_q = tap_addr_q; ref_data_q = tap_data_q;
    ref_first_q = tap_first_q; ref_last_q = tap_last_q;
    $display("conv nohold: taps=%0d done_after=%0d", tap_addr_q.size(), done_cyc - c0);

    // Gapped load; a conv_start during LOAD must be ignored
    clear_taps();
    wr_cnt = 0; wr_idx = 0; wr_bad = 0; rdy_bad = 0;
    load_img(1024, 1'b1, 300);
    check("gap_load_done", {31'd0, load_done}, 32'd1);
    tick();
    check("gap_wr_cnt", wr_cnt, 32'd1024);
    check("gap_wr_bad", wr_bad, 32'd0);
    check("gap_rdy_bad", rdy_bad, 32'd0);
    check("gap_no_taps", tap_addr_q.size(), 32'd0);
    check("gap_ram", ram_bad(), 32'd0);
    $display("load gapped: writes=%0d", wr_cnt);

    // Scan with a 10-cycle hold placed mid-window
    clear_taps();
    w = $urandom_range(70, 10) * 25 + $urandom_range(23, 1);
    conv_start = 1'b1;
    c0 = cyc;
    tick();
    conv_start = 1'b0;
    repeat (w) tick();
    conv_hold = 1'b1;
    h = cyc;
    check("hold_raddr_enter", {22'd0, f1_raddr}, win_addr(w));
    repeat (9) tick();
    check("hold_raddr_frozen", {22'd0, f1_raddr}, win_addr(w));
    tick();
    conv_hold = 1'b0;
    wait_done(25000);
    in_win = 0; late = 0;
    foreach (tap_cyc_q[i]) begin
      if (tap_cyc_q[i] >= h && tap_cyc_q[i] <= h + 11) in_win++;
      if (tap_cyc_q[i] >= h + 2 && tap_cyc_q[i] <= h + 11) late++;
    end
    check("hold_taps_after_rise", in_win, 32'd2);
    check("hold_taps_late", late, 32'd0);
    check("hold_done_latency", done_cyc - c0, 32'd19613);
    check("hold_taps", tap_addr_q.size(), ref_addr_q.size());
    bad = 0;
    for (int t = 0; t < tap_addr_q.size() && t < ref_addr_q.size(); t++)
      if (tap_addr_q[t] != ref_addr_q[t] || tap_data_q[t] !== ref_data_q[t] ||
          tap_first_q[t] != ref_first_q[t] || tap_last_q[t] != ref_last_q[t]) bad++;
    check("hold_tap_seq", bad, 32'd0);
`ifdef F1_CTRL_PERF_EN
    check("perf_hold", perf_cycles, 32'd19613);
`endif
    $display("conv hold: at_tap=%0d taps=%0d done_after=%0d", w, tap_addr_q.size(), done_cyc - c0);

    // Reset after 500 beats, then full reload with a new random image
    for (int i = 0; i < 1024; i++) pat[i] = 8'($urandom);
    load_img(500, 1'b0, -1);
    rst = 1'b1;
    tick();
    check("midrst_pix_ready", {31'd0, pix_ready}, 32'd0);
    tick();
    check("midrst_load_done", {31'd0, load_done}, 32'd0);
    rst = 1'b0;
    wr_cnt = 0; wr_idx = 0; wr_bad = 0; rdy_bad = 0;
    for (int i = 0; i < 1024; i++) pat[i] = 8'($urandom);
    load_img(1024, 1'b0, -1);
    check("reload_load_done", {31'd0, load_done}, 32'd1);
    tick();
    check("reload_wr_cnt", wr_cnt, 32'd1024);
    check("reload_wr_bad", wr_bad, 32'd0);
    check("reload_ram", ram_bad(), 32'd0);
    $display("reload after reset: writes=%0d", wr_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/f1_ctrl.md
Name: f1_ctrl

Overview:
- Sequencer for the conv-layer-1 feature RAM.
- LOAD phase: accepts the 32x32 8-bit input image as a valid/ready byte stream and drives the RAM write port.
- CONV phase: on start, walks every 5x5 window of the 28x28 valid-convolution output and issues one read address per tap. Tags the returning RAM data (2-cycle read latency) with valid, first-of-window and last-of-window markers for the conv1 PE array.

Parameters:
- IMG_W, 32, image width in pixels.
- IMG_H, 32, image height in pixels; IMG_W*IMG_H must be at most 1024.
- K, 5, square kernel size.
- RD_LAT, 2, RAM read latency in clocks (pipeline depth of the tag path).

Ports:
- clk  in  1  single clock, drives both RAM ports.
- rst  in  1  synchronous active-high reset.
- pix_in  in  8  input pixel.
- pix_valid  in  1  input pixel valid.
- pix_ready  out  1  controller accepts a pixel this cycle.
- load_done  out  1  image fully written (level).
- conv_start  in  1  one-cycle pulse; begins window scan.
- conv_hold  in  1  freezes address generation while high.
- f1_wr_en  out  4  RAM byte write enables.
- f1_waddr  out  32  RAM byte write address.
- f1_wdata  out  32  RAM write data.
- f1_ena  out  1  RAM port-A enable.
- f1_raddr  out  10  RAM word read address (pixel index).
- f1_rdata  in  8  RAM read data.
- tap_data  out  8  pixel delivered to PE (f1_rdata passthrough).
- tap_valid  out  1  tap_data valid.
- win_first  out  1  tap is (ky=0,kx=0) of a window.
- win_last  out  1  tap is (ky=K-1,kx=K-1) of a window.
- conv_done  out  1  one-cycle pulse after the final tap is delivered.
- busy  out  1  high in LOAD-accepting or CONV states.

Behaviour:
- Reset values: all outputs 0. pix_ready is 0 during reset. FSM enters LOAD on the first cycle after rst deasserts.
- States: LOAD, LOADED, CONV, DRAIN.
- LOAD:
  - pix_ready=1, busy=1.
  - Each cycle with pix_valid&pix_ready writes pixel index n: f1_ena=1, f1_wr_en=4'hF, f1_waddr={20'b0,n[9:0],2'b00}, f1_wdata={24'b0,pix_in}. n then increments.
  - Write outputs are registered (1-cycle latency) and return to 0 on cycles with no accepted pixel.
  - After index IMG_W*IMG_H-1 is accepted: go to LOADED; pix_ready drops the next cycle.
- LOADED:
  - load_done=1, busy=0, pix_ready=0.
  - conv_start moves to CONV. conv_start in any other state is ignored.
- CONV:
  - Counters nest outermost to innermost: oy 0..IMG_H-K, ox 0..IMG_W-K, ky 0..K-1, kx 0..K-1.
  - Each non-hold cycle issues f1_raddr=(oy+ky)*IMG_W+(ox+kx) and advances kx, carrying into ky, ox, oy.
  - Issue flag, first flag and last flag travel through an RD_LAT-deep shift register.
  - tap_valid/win_first/win_last appear exactly RD_LAT cycles after the address. tap_data=f1_rdata in that cycle.
  - conv_hold=1: no address issued, counters frozen, f1_raddr holds its value. Reads already in flight still emerge, so at most RD_LAT taps follow a hold assertion.
  - After the last address (oy=ox=IMG_H-K, ky=kx=K-1) is issued: go to DRAIN.
- DRAIN:
  - Wait until the shift register is empty.
  - conv_done pulses in the cycle after the final tap_valid. Then return to LOAD with n=0 and load_done=0.
- Totals: 28*28*25 = 19600 taps per image. With no hold, the first tap appears RD_LAT cycles after the first CONV cycle, and conv_done follows 19600+RD_LAT+1 cycles after conv_start.
- Arithmetic: the raddr product is computed in 10 bits with no overflow, given the parameter constraint.
- Reset mid-operation: counters, shift register and FSM clear on the next edge; a partial image is discarded and reloading restarts at index 0.
- Write and read port activity never overlap.

Optional Feature:
- F1_CTRL_PERF_EN defined: adds output perf_cycles (32 bits). It clears on conv_start, counts every cycle in CONV/DRAIN including held cycles, and freezes when conv_done fires.
- Not defined: port and counter are absent; no other change.

Test Plan:
- Load ramp pixel[n]=n[7:0], 1024 back-to-back beats: 1024 writes seen; last write has f1_waddr=0x00000FFC, f1_wdata=0x000000FF; load_done high 1 cycle after the last beat; pix_ready then 0.
- Gapped load (pix_valid toggling each cycle): still exactly 1024 writes, addresses contiguous, no write on idle cycles.
- conv_start with no hold, behavioural RAM with 2-cycle latency: 19600 tap_valid.
  - First raddr sequence 0,1,2,3,4,32,33,…
  - Window 0 tap data matches ramp.
  - Last window's first raddr = 27*32+27 = 891.
  - 784 win_first and 784 win_last pulses.
  - conv_done at conv_start+19603.
- conv_hold high for 10 cycles mid-window: exactly 2 taps after hold rises, then none; the scan resumes at the correct next address; the tap sequence is identical to the no-hold run.
- rst asserted after 500 load beats, then a full reload with a new pattern: the RAM model holds only new data at indices 0..1023; load_done asserts only after the full 1024.
- With F1_CTRL_PERF_EN: perf_cycles=19603 after a no-hold run; 19613 with one 10-cycle hold.
